// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the multi-cycle CLA subtractor.
package cla_pkg;

  localparam int CLA_WIDTH = 64;
  localparam int CLA_SLICE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } cla_state_t;

endpackage

// File: rtl/cla_slice_16bit.sv
// Combinational 16-bit carry-lookahead adder slice: four 4-bit groups with
// group generate/propagate, and a lookahead level across the groups.
module cla_slice_16bit (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = x & y;
  assign p = x ^ y;

  // Group generate/propagate for each 4-bit nibble.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int i = 0; i < 4; i++) begin
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];
    end
  end

  // Second-level lookahead: every group carry is a flat function of cin.
  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  // Sum bits: carries inside a nibble derive from that nibble's group carry.
  always_comb begin
    logic c_run;
    s     = '0;
    c_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_run = grp_c[i];
      for (int j = 0; j < 4; j++) begin
        s[4*i+j] = p[4*i+j] ^ c_run;
        c_run    = g[4*i+j] | (p[4*i+j] & c_run);
      end
    end
  end

  assign cout = grp_c[4];

endmodule

// File: rtl/carry_lookahead_subtractor_64bit.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, evaluated as
// a + ~b + ~borrow_in, one 16-bit CLA slice per clock.
// Optional macro CLA_SUB_FLAGS_EN enables the registered zero/overflow flags;
// without it both ports are tied low.
module carry_lookahead_subtractor_64bit
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SLICE = CLA_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done,
  output logic             zero,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  cla_state_t       state, state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_n_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             accept;
  logic             last;
  logic [SLICE-1:0] slice_s;
  logic             slice_cout;

  assign accept = (state == IDLE) && start;
  assign last   = (state == CALC) && (idx_q == LAST_IDX);

  cla_slice_16bit u_slice (
    .x    (a_q[idx_q*SLICE +: SLICE]),
    .y    (b_n_q[idx_q*SLICE +: SLICE]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-slice accumulation of the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_n_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_n_q   <= ~b;
      carry_q <= ~borrow_in;
      idx_q   <= '0;
    end else if (state == CALC) begin
      diff_q[idx_q*SLICE +: SLICE] <= slice_s;
      carry_q <= slice_cout;
      idx_q   <= idx_q + 1'b1;
      if (last) borrow_q <= ~slice_cout;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

`ifdef CLA_SUB_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Flags settle on the final slice edge; lower slices are already in diff_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last) begin
      zero_q <= (diff_q[WIDTH-SLICE-1:0] == '0) && (slice_s == '0);
      ovf_q  <= (a_q[WIDTH-1] == b_n_q[WIDTH-1]) && (slice_s[SLICE-1] != a_q[WIDTH-1]);
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_carry_lookahead_subtractor_64bit.sv
// Directed self-checking bench for carry_lookahead_subtractor_64bit.
module tb_carry_lookahead_subtractor_64bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        borrow_in;
  logic        busy;
  logic [63:0] diff;
  logic        borrow_out;
  logic        done;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  carry_lookahead_subtractor_64bit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .diff       (diff),
    .borrow_out (borrow_out),
    .done       (done),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flags only exist when the option is compiled in.
  function automatic logic flag_exp(input logic v);
`ifdef CLA_SUB_FLAGS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation, optionally poke start mid-CALC, and check the result.
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tbi, input logic [63:0] exp_diff, input logic exp_bo,
                        input logic exp_zero, input logic exp_ovf, input logic poke);
    int lat;
    int dones;
    @(negedge clk);
    a = ta; b = tb_v; borrow_in = tbi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; borrow_in = ~tbi;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat   = 0;
    dones = 0;
    while (!done && lat < 20) begin
      if (poke && lat == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_diff"}, diff, exp_diff);
    check({tag, "_borrow"}, 64'(borrow_out), 64'(exp_bo));
    check({tag, "_zero"}, 64'(zero), 64'(flag_exp(exp_zero)));
    check({tag, "_ovf"}, 64'(overflow), 64'(flag_exp(exp_ovf)));
    if (done) dones++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check({tag, "_done_pulses"}, 64'(dones), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_diff_hold"}, diff, exp_diff);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_borrow", 64'(borrow_out), 64'd0);
    check("rst_flags", {62'd0, zero, overflow}, 64'd0);
    reset = 1'b0;

    run_op("basic", 64'h2222_2222_2222_2211, 64'h0FED_CBA9_8765_4321, 1'b0,
           64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("zero_minus_one", 64'h0, 64'h1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("all_ones_bi", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("signed_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("equal_poke", 64'd5, 64'd5, 1'b0,
           64'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset during the second CALC cycle.
    @(negedge clk);
    a = 64'h1234; b = 64'h1; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_diff", diff, 64'd0);
    check("midrst_borrow", 64'(borrow_out), 64'd0);
    check("midrst_flags", {62'd0, zero, overflow}, 64'd0);
    reset = 1'b0;

    run_op("after_rst", 64'h0000_0001_0000_0000, 64'h1, 1'b1,
           64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
